// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key sequencer.
// Also holds the shift-dependent ASCII case translation helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BRK     = 3'd1,
    EXT     = 3'd2,
    EXT_BRK = 3'd3,
    LOOKUP  = 3'd4
  } ps2_state_e;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [7:0] LSHIFT     = 8'h12;
  localparam logic [7:0] RSHIFT     = 8'h59;

  localparam int DEFAULT_FIFO_DEPTH = 8;

  // Held shift upper-cases letters; a released shift lower-cases them.
  function automatic logic [7:0] ascii_xlate(input logic shift, input logic [7:0] a);
    logic [7:0] r;
    if (shift && (a >= 8'h61) && (a <= 8'h7A)) begin
      r = a - 8'h20;
    end else if (!shift && (a >= 8'h41) && (a <= 8'h5A)) begin
      r = a + 8'h20;
    end else begin
      r = a;
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_ascii_fifo.sv
// First-word-fall-through byte FIFO for translated ASCII characters.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module ps2_ascii_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == {(AW+1){1'b0}});
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? 8'h00 : mem_q[rd_q];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= {AW{1'b0}};
      rd_q  <= {AW{1'b0}};
      cnt_q <= {(AW+1){1'b0}};
    end else begin
      if (do_push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Decodes PS/2 set-2 make/break/extended sequences, tracks shift and queues
// ASCII bytes from an external keycode lookup into a FWFT FIFO.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       scan_ready,
  output logic [7:0] keycode,
  input  logic [7:0] a_code,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       shift_held,
  output logic       overflow,
  input  logic       overflow_clr
);

  ps2_state_e state_q, state_d;
  logic [7:0] keycode_q, keycode_d;
  logic       shift_q, shift_d;
  logic       overflow_q, overflow_d;
  logic       accept;
  logic       is_shift;
  logic       push;
  logic       drop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] push_data;

  assign scan_ready = (state_q != LOOKUP);
  assign accept     = scan_valid && scan_ready;
  assign is_shift   = (scan_code == LSHIFT) || (scan_code == RSHIFT);
  assign push_data  = ascii_xlate(shift_q, a_code);
  // A full FIFO only loses the byte when the consumer is not popping this cycle.
  assign drop       = push && fifo_full && !out_ready;

  always_comb begin
    state_d    = state_q;
    keycode_d  = keycode_q;
    shift_d    = shift_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (scan_code == BREAK_CODE) begin
            state_d = BRK;
          end else if (scan_code == EXT_CODE) begin
            state_d = EXT;
          end else if (is_shift) begin
            shift_d = 1'b1;
          end else begin
            keycode_d = scan_code;
            state_d   = LOOKUP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BRK: begin
        if (accept) begin
          shift_d = is_shift ? 1'b0 : shift_q;
          state_d = IDLE;
        end else begin
          state_d = BRK;
        end
      end
      EXT: begin
        if (accept) begin
          state_d = (scan_code == BREAK_CODE) ? EXT_BRK : IDLE;
        end else begin
          state_d = EXT;
        end
      end
      EXT_BRK: begin
        if (accept) begin
          state_d = IDLE;
        end else begin
          state_d = EXT_BRK;
        end
      end
      LOOKUP: begin
        push    = (a_code != 8'h00);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      keycode_q  <= 8'h00;
      shift_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      keycode_q  <= keycode_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
    end
  end

  ps2_ascii_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out_data)
  );

  assign out_valid  = !fifo_empty;
  assign keycode    = keycode_q;
  assign shift_held = shift_q;
  assign overflow   = overflow_q;

endmodule
